// File: rtl/mib_slave_responder_pkg.sv
// Shared types and constants for the MIB slave responder.
// Optional statistics counters are enabled with the MIB_SLAVE_STATS_EN macro (see top).
package mib_slave_responder_pkg;

    localparam int MIB_AD_BITS        = 16;
    localparam int CMD_DATA_BITS      = 32;
    localparam int CMD_ADDR_BITS      = 24;
    localparam int CMD_BYTE_ADDR_BITS = 20;

    // addr[19:16] arrives in the low nibble of phase A1.
    localparam int ADDR_HI_BITS = CMD_BYTE_ADDR_BITS - MIB_AD_BITS;
    // Phase A1 carries addr[23:16], so address bit b sits at ad bit b-A1_ADDR_LSB.
    localparam int A1_ADDR_LSB  = CMD_ADDR_BITS - 8;
    // Slave-select nibble addr[23:20] as seen inside phase A1.
    localparam int MSN_HI       = CMD_ADDR_BITS - 1 - A1_ADDR_LSB;
    localparam int MSN_LO       = CMD_BYTE_ADDR_BITS - A1_ADDR_LSB;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR2    = 4'd1,
        S_WDATA1   = 4'd2,
        S_WDATA2   = 4'd3,
        S_CMD_REQ  = 4'd4,
        S_CMD_WAIT = 4'd5,
        S_RD_HI    = 4'd6,
        S_RD_LO    = 4'd7,
        S_WR_ACK   = 4'd8,
        S_SKIP     = 4'd9
    } mib_slv_state_t;

    // Slave-select nibble carried in phase A1.
    function automatic logic [MSN_HI-MSN_LO:0] a1_msn(input logic [MIB_AD_BITS-1:0] ad);
        return ad[MSN_HI:MSN_LO];
    endfunction

    // addr[19:16] carried in phase A1.
    function automatic logic [ADDR_HI_BITS-1:0] a1_addr_hi(input logic [MIB_AD_BITS-1:0] ad);
        return ad[ADDR_HI_BITS-1:0];
    endfunction

endpackage

// File: rtl/mib_slave_responder_if.sv
// MIB pad-side and local cmd-bus signals of the slave responder.
//
// Handshake: i_mib_start is a 1-clk strobe that marks phase A1; the remaining
// phases follow on consecutive clocks with no stall. o_cmd_sel is a 1-clk
// request whose address/data/direction stay held until the responder returns
// to idle; i_cmd_ack is a 1-clk completion strobe that only counts while the
// responder is waiting for it (i_cmd_rdata valid in that same clock).
// o_mib_slave_ack pulses once for a write, or twice (with o_mib_ad_oe) to
// carry read data high half then low half.
interface mib_slave_responder_if;
    import mib_slave_responder_pkg::*;

    logic                          i_mib_start;
    logic                          i_mib_rd_wr_n;
    logic [MIB_AD_BITS-1:0]        i_mib_ad;
    logic [MIB_AD_BITS-1:0]        o_mib_ad;
    logic                          o_mib_ad_oe;
    logic                          o_mib_slave_ack;
    logic                          o_cmd_sel;
    logic                          o_cmd_rd_wr_n;
    logic [CMD_BYTE_ADDR_BITS-1:0] o_cmd_byte_addr;
    logic [CMD_DATA_BITS-1:0]      o_cmd_wdata;
    logic [CMD_DATA_BITS-1:0]      i_cmd_rdata;
    logic                          i_cmd_ack;
    logic                          o_cmd_timeout;

    modport slave (
        input  i_mib_start, i_mib_rd_wr_n, i_mib_ad, i_cmd_rdata, i_cmd_ack,
        output o_mib_ad, o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_rd_wr_n,
               o_cmd_byte_addr, o_cmd_wdata, o_cmd_timeout
    );

    // Environment side: MIB master plus local register fabric.
    modport master (
        output i_mib_start, i_mib_rd_wr_n, i_mib_ad, i_cmd_rdata, i_cmd_ack,
        input  o_mib_ad, o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_rd_wr_n,
               o_cmd_byte_addr, o_cmd_wdata, o_cmd_timeout
    );

endinterface

// File: rtl/mib_slave_responder_ack_timer.sv
// Local-ack watchdog for the MIB slave responder: load starts the count at 1,
// it advances once per clock and parks at P_TIMEOUT (expire) until cleared.
module mib_cmd_ack_timer #(
    parameter int P_TIMEOUT = 16,
    localparam int W = $clog2(P_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic expire
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == W'(P_TIMEOUT));

    // Load wins over clear; an idle (zero) or expired count does not move.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(1);
        end else if (clear) begin
            cnt_d = '0;
        end else if ((cnt_q != '0) && !expire) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mib_slave_responder.sv
// MIB slave responder: decodes MIB address/data phases and replays each
// transfer as one local cmd-bus access, then acks the write or returns the
// read data as two 16-bit phases. All outputs are registered.
// Define MIB_SLAVE_STATS_EN to add write/read/timeout event counters.
module mib_slave_responder
    import mib_slave_responder_pkg::*;
#(
    parameter logic [3:0] P_SLAVE_MSN            = 4'h0,
    parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
    input  logic                  i_sysclk,
    input  logic                  i_rst_n,
    mib_slave_responder_if.slave  bus,
`ifdef MIB_SLAVE_STATS_EN
    output logic [15:0]           o_stat_wr_cnt,
    output logic [15:0]           o_stat_rd_cnt,
    output logic [15:0]           o_stat_to_cnt,
`endif
    output mib_slv_state_t        o_dbg_state
);

    mib_slv_state_t                state_q, state_d;
    logic [1:0]                    skip_q, skip_d;      // phases still to discard
    logic                          rd_q, rd_d;          // 1 = read transfer
    logic [ADDR_HI_BITS-1:0]       addr_hi_q, addr_hi_d;
    logic [MIB_AD_BITS-1:0]        addr_lo_q, addr_lo_d;
    logic [CMD_DATA_BITS-1:0]      wdata_q, wdata_d;
    logic [MIB_AD_BITS-1:0]        rdata_lo_q, rdata_lo_d;

    logic [MIB_AD_BITS-1:0]        mib_ad_q, mib_ad_d;
    logic                          mib_ad_oe_q, mib_ad_oe_d;
    logic                          mib_ack_q, mib_ack_d;
    logic                          cmd_sel_q, cmd_sel_d;
    logic                          cmd_rd_wr_n_q, cmd_rd_wr_n_d;
    logic [CMD_BYTE_ADDR_BITS-1:0] cmd_byte_addr_q, cmd_byte_addr_d;
    logic [CMD_DATA_BITS-1:0]      cmd_wdata_q, cmd_wdata_d;
    logic                          cmd_timeout_q, cmd_timeout_d;

    logic                          timer_load;
    logic                          timer_clear;
    logic                          timer_expire;

    mib_cmd_ack_timer #(
        .P_TIMEOUT (P_CMD_ACK_TIMEOUT_CLKS)
    ) u_ack_timer (
        .clk    (i_sysclk),
        .rst_n  (i_rst_n),
        .load   (timer_load),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    // Next-state and next-output logic; outputs are computed one clock ahead
    // so every pad/cmd output comes straight from a flop.
    always_comb begin
        state_d         = state_q;
        skip_d          = skip_q;
        rd_d            = rd_q;
        addr_hi_d       = addr_hi_q;
        addr_lo_d       = addr_lo_q;
        wdata_d         = wdata_q;
        rdata_lo_d      = rdata_lo_q;
        mib_ad_d        = '0;
        mib_ad_oe_d     = 1'b0;
        mib_ack_d       = 1'b0;
        cmd_sel_d       = 1'b0;
        cmd_rd_wr_n_d   = cmd_rd_wr_n_q;
        cmd_byte_addr_d = cmd_byte_addr_q;
        cmd_wdata_d     = cmd_wdata_q;
        cmd_timeout_d   = 1'b0;
        timer_load      = 1'b0;
        timer_clear     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_mib_start) begin
                    rd_d      = bus.i_mib_rd_wr_n;
                    addr_hi_d = a1_addr_hi(bus.i_mib_ad);
                    if (a1_msn(bus.i_mib_ad) != P_SLAVE_MSN) begin
                        // Not ours: swallow A2, plus D1/D2 for a write.
                        skip_d  = bus.i_mib_rd_wr_n ? 2'd1 : 2'd3;
                        state_d = S_SKIP;
                    end else begin
                        state_d = S_ADDR2;
                    end
                end
            end
            S_ADDR2: begin
                addr_lo_d = bus.i_mib_ad;
                state_d   = rd_q ? S_CMD_REQ : S_WDATA1;
            end
            S_WDATA1: begin
                wdata_d[CMD_DATA_BITS-1:MIB_AD_BITS] = bus.i_mib_ad;
                state_d = S_WDATA2;
            end
            S_WDATA2: begin
                wdata_d[MIB_AD_BITS-1:0] = bus.i_mib_ad;
                state_d = S_CMD_REQ;
            end
            S_CMD_REQ: begin
                timer_load = 1'b1;
                state_d    = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                // Ack is checked first so it wins over a same-clock expiry.
                if (bus.i_cmd_ack) begin
                    timer_clear = 1'b1;
                    mib_ack_d   = 1'b1;
                    if (rd_q) begin
                        mib_ad_d    = bus.i_cmd_rdata[CMD_DATA_BITS-1:MIB_AD_BITS];
                        mib_ad_oe_d = 1'b1;
                        rdata_lo_d  = bus.i_cmd_rdata[MIB_AD_BITS-1:0];
                        state_d     = S_RD_HI;
                    end else begin
                        state_d     = S_WR_ACK;
                    end
                end else if (timer_expire) begin
                    // No MIB ack: the master runs into its own timeout.
                    timer_clear   = 1'b1;
                    cmd_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_RD_HI: begin
                mib_ad_d    = rdata_lo_q;
                mib_ad_oe_d = 1'b1;
                mib_ack_d   = 1'b1;
                state_d     = S_RD_LO;
            end
            S_RD_LO: begin
                state_d = S_IDLE;
            end
            S_WR_ACK: begin
                state_d = S_IDLE;
            end
            S_SKIP: begin
                if (skip_q == 2'd1) begin
                    state_d = S_IDLE;
                end else begin
                    skip_d = skip_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Launch the local access with the freshly completed address/data.
        if (state_d == S_CMD_REQ) begin
            cmd_sel_d       = 1'b1;
            cmd_rd_wr_n_d   = rd_d;
            cmd_byte_addr_d = {addr_hi_d, addr_lo_d};
            cmd_wdata_d     = wdata_d;
        end
    end

    // State, capture and output registers.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= S_IDLE;
            skip_q          <= '0;
            rd_q            <= 1'b0;
            addr_hi_q       <= '0;
            addr_lo_q       <= '0;
            wdata_q         <= '0;
            rdata_lo_q      <= '0;
            mib_ad_q        <= '0;
            mib_ad_oe_q     <= 1'b0;
            mib_ack_q       <= 1'b0;
            cmd_sel_q       <= 1'b0;
            cmd_rd_wr_n_q   <= 1'b0;
            cmd_byte_addr_q <= '0;
            cmd_wdata_q     <= '0;
            cmd_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            skip_q          <= skip_d;
            rd_q            <= rd_d;
            addr_hi_q       <= addr_hi_d;
            addr_lo_q       <= addr_lo_d;
            wdata_q         <= wdata_d;
            rdata_lo_q      <= rdata_lo_d;
            mib_ad_q        <= mib_ad_d;
            mib_ad_oe_q     <= mib_ad_oe_d;
            mib_ack_q       <= mib_ack_d;
            cmd_sel_q       <= cmd_sel_d;
            cmd_rd_wr_n_q   <= cmd_rd_wr_n_d;
            cmd_byte_addr_q <= cmd_byte_addr_d;
            cmd_wdata_q     <= cmd_wdata_d;
            cmd_timeout_q   <= cmd_timeout_d;
        end
    end

    assign bus.o_mib_ad        = mib_ad_q;
    assign bus.o_mib_ad_oe     = mib_ad_oe_q;
    assign bus.o_mib_slave_ack = mib_ack_q;
    assign bus.o_cmd_sel       = cmd_sel_q;
    assign bus.o_cmd_rd_wr_n   = cmd_rd_wr_n_q;
    assign bus.o_cmd_byte_addr = cmd_byte_addr_q;
    assign bus.o_cmd_wdata     = cmd_wdata_q;
    assign bus.o_cmd_timeout   = cmd_timeout_q;
    assign o_dbg_state         = state_q;

`ifdef MIB_SLAVE_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_to_q, stat_to_d;

    // One event per completed write, completed read and local timeout; wraps.
    always_comb begin
        stat_wr_d = stat_wr_q + ((state_q == S_WR_ACK) ? 16'd1 : 16'd0);
        stat_rd_d = stat_rd_q + ((state_q == S_RD_LO)  ? 16'd1 : 16'd0);
        stat_to_d = stat_to_q + (cmd_timeout_q         ? 16'd1 : 16'd0);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
            stat_to_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
            stat_to_q <= stat_to_d;
        end
    end

    assign o_stat_wr_cnt = stat_wr_q;
    assign o_stat_rd_cnt = stat_rd_q;
    assign o_stat_to_cnt = stat_to_q;
`endif

endmodule

// File: tb/tb_mib_slave_responder.sv
// Directed bench for mib_slave_responder: writes, reads, foreign-MSN skip,
// local-ack timeout and its ack-wins boundary, start during a transfer,
// reset in the middle of read data, and (with MIB_SLAVE_STATS_EN) counters.
module tb_mib_slave_responder;
    import mib_slave_responder_pkg::*;

    localparam int TO = 16;

    logic           sysclk;
    logic           rst_n;
    mib_slave_responder_if bus();
    mib_slv_state_t dbg_state;
`ifdef MIB_SLAVE_STATS_EN
    logic [15:0]    stat_wr;
    logic [15:0]    stat_rd;
    logic [15:0]    stat_to;
`endif

    int errors = 0;
    int checks = 0;

    // Per-cycle event tallies sampled mid-cycle.
    int sel_n = 0;
    int ack_n = 0;
    int oe_n  = 0;
    int to_n  = 0;
    int s_sel, s_ack, s_oe;

    mib_slave_responder #(
        .P_SLAVE_MSN            (4'h0),
        .P_CMD_ACK_TIMEOUT_CLKS (TO)
    ) dut (
        .i_sysclk      (sysclk),
        .i_rst_n       (rst_n),
        .bus           (bus),
`ifdef MIB_SLAVE_STATS_EN
        .o_stat_wr_cnt (stat_wr),
        .o_stat_rd_cnt (stat_rd),
        .o_stat_to_cnt (stat_to),
`endif
        .o_dbg_state   (dbg_state)
    );

    // Clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Event tallies.
    always @(negedge sysclk) begin
        sel_n += int'(bus.o_cmd_sel);
        ack_n += int'(bus.o_mib_slave_ack);
        oe_n  += int'(bus.o_mib_ad_oe);
        to_n  += int'(bus.o_cmd_timeout);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Present one MIB phase for one clock.
    task automatic drive_phase(input logic st, input logic rw, input logic [15:0] ad);
        bus.i_mib_start   = st;
        bus.i_mib_rd_wr_n = rw;
        bus.i_mib_ad      = ad;
        tick();
    endtask

    // Full transfer. ack_at = CMD_WAIT clock (1..TO) carrying i_cmd_ack, 0 = never.
    // start_at = CMD_WAIT clock carrying a stray start, 0 = none.
    // early_ack = pulse i_cmd_ack during the CMD_REQ clock (must be ignored).
    task automatic run_xfer(input string tag, input logic rd, input logic [23:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdat,
                            input int ack_at, input int start_at, input logic early_ack);
        int  p_sel, p_ack, p_oe, p_to;
        bit  done;
        p_sel = sel_n;
        p_ack = ack_n;
        p_oe  = oe_n;
        p_to  = to_n;
        done  = 1'b0;
        // A1 upper byte is don't-care; fill it with junk.
        drive_phase(1'b1, rd, {8'hA5, addr[23:16]});
        drive_phase(1'b0, rd, addr[15:0]);
        if (!rd) begin
            drive_phase(1'b0, rd, wd[31:16]);
            drive_phase(1'b0, rd, wd[15:0]);
        end
        bus.i_mib_ad = '0;
        // Now in the CMD_REQ clock.
        chk({tag, "_sel"}, 32'(bus.o_cmd_sel), 32'd1);
        chk({tag, "_addr"}, 32'(bus.o_cmd_byte_addr), 32'(addr[19:0]));
        chk({tag, "_rw"}, 32'(bus.o_cmd_rd_wr_n), 32'(rd));
        if (!rd) chk({tag, "_wdata"}, bus.o_cmd_wdata, wd);
        bus.i_cmd_ack = early_ack;
        for (int c = 1; c <= TO && !done; c++) begin
            tick();
            bus.i_cmd_ack   = 1'b0;
            bus.i_mib_start = (c == start_at);
            bus.i_mib_rd_wr_n = 1'b1;
            if (c == 1) begin
                chk({tag, "_sel_off"}, 32'(bus.o_cmd_sel), 32'd0);
                chk({tag, "_wait"}, 32'(dbg_state), 32'(S_CMD_WAIT));
            end
            if (c == TO) chk({tag, "_wait_last"}, 32'(dbg_state), 32'(S_CMD_WAIT));
            if (c == ack_at) begin
                done = 1'b1;
                bus.i_mib_start = 1'b0;
                bus.i_cmd_ack   = 1'b1;
                bus.i_cmd_rdata = rdat;
                tick();
                bus.i_cmd_ack   = 1'b0;
                bus.i_cmd_rdata = '0;
                chk({tag, "_no_to"}, 32'(bus.o_cmd_timeout), 32'd0);
                chk({tag, "_held_addr"}, 32'(bus.o_cmd_byte_addr), 32'(addr[19:0]));
                if (rd) begin
                    chk({tag, "_hi"}, 32'(bus.o_mib_ad), 32'(rdat[31:16]));
                    chk({tag, "_hi_ack"}, 32'(bus.o_mib_slave_ack), 32'd1);
                    chk({tag, "_hi_oe"}, 32'(bus.o_mib_ad_oe), 32'd1);
                    tick();
                    chk({tag, "_lo"}, 32'(bus.o_mib_ad), 32'(rdat[15:0]));
                    chk({tag, "_lo_ack"}, 32'(bus.o_mib_slave_ack), 32'd1);
                    chk({tag, "_lo_oe"}, 32'(bus.o_mib_ad_oe), 32'd1);
                    tick();
                    chk({tag, "_oe_drop"}, 32'(bus.o_mib_ad_oe), 32'd0);
                end else begin
                    chk({tag, "_wack"}, 32'(bus.o_mib_slave_ack), 32'd1);
                    chk({tag, "_wack_oe"}, 32'(bus.o_mib_ad_oe), 32'd0);
                    tick();
                end
                chk({tag, "_ack_end"}, 32'(bus.o_mib_slave_ack), 32'd0);
                chk({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
            end
        end
        bus.i_mib_start = 1'b0;
        if (!done) begin
            tick();
            chk({tag, "_to"}, 32'(bus.o_cmd_timeout), 32'd1);
            chk({tag, "_to_idle"}, 32'(dbg_state), 32'(S_IDLE));
            chk({tag, "_to_ack"}, 32'(bus.o_mib_slave_ack), 32'd0);
            tick();
            chk({tag, "_to_end"}, 32'(bus.o_cmd_timeout), 32'd0);
            tick();
            chk({tag, "_to_stay"}, 32'(dbg_state), 32'(S_IDLE));
        end
        chk({tag, "_nsel"}, 32'(sel_n - p_sel), 32'd1);
        chk({tag, "_nack"}, 32'(ack_n - p_ack), (ack_at == 0) ? 32'd0 : (rd ? 32'd2 : 32'd1));
        chk({tag, "_noe"}, 32'(oe_n - p_oe), (rd && ack_at != 0) ? 32'd2 : 32'd0);
        chk({tag, "_nto"}, 32'(to_n - p_to), (ack_at == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_mib_start   = 1'b0;
        bus.i_mib_rd_wr_n = 1'b0;
        bus.i_mib_ad      = '0;
        bus.i_cmd_rdata   = '0;
        bus.i_cmd_ack     = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_ad", 32'(bus.o_mib_ad), 32'd0);
        chk("rst_oe", 32'(bus.o_mib_ad_oe), 32'd0);
        chk("rst_ack", 32'(bus.o_mib_slave_ack), 32'd0);
        chk("rst_sel", 32'(bus.o_cmd_sel), 32'd0);
        chk("rst_rw", 32'(bus.o_cmd_rd_wr_n), 32'd0);
        chk("rst_addr", 32'(bus.o_cmd_byte_addr), 32'd0);
        chk("rst_wdata", bus.o_cmd_wdata, 32'd0);
        chk("rst_to", 32'(bus.o_cmd_timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write, local ack in the third wait clock.
        run_xfer("wr0", 1'b0, 24'h000004, 32'h0101_0202, 32'h0, 3, 0, 1'b0);
        // Basic read, ack in the same clock sel drops.
        run_xfer("rd0", 1'b1, 24'h000008, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);

        // Write to MSN 3: swallowed silently; stray ack in between is ignored.
        s_sel = sel_n;
        s_ack = ack_n;
        s_oe  = oe_n;
        drive_phase(1'b1, 1'b0, 16'h0030);
        chk("skip_state", 32'(dbg_state), 32'(S_SKIP));
        bus.i_cmd_ack   = 1'b1;
        bus.i_cmd_rdata = 32'hFFFF_FFFF;
        drive_phase(1'b0, 1'b0, 16'h0010);
        bus.i_cmd_ack   = 1'b0;
        bus.i_cmd_rdata = '0;
        drive_phase(1'b0, 1'b0, 16'hAAAA);
        drive_phase(1'b0, 1'b0, 16'h5555);
        bus.i_mib_ad = '0;
        chk("skip_idle", 32'(dbg_state), 32'(S_IDLE));
        tick();
        tick();
        chk("skip_nsel", 32'(sel_n - s_sel), 32'd0);
        chk("skip_nack", 32'(ack_n - s_ack), 32'd0);
        chk("skip_noe", 32'(oe_n - s_oe), 32'd0);
        run_xfer("rd1", 1'b1, 24'h00000C, 32'h0, 32'h1234_5678, 2, 0, 1'b0);

        // No local ack: timeout; early ack and stray start are both ignored.
        run_xfer("rd_to", 1'b1, 24'h000010, 32'h0, 32'h0, 0, 3, 1'b1);
        // Ack in the last wait clock beats the timeout.
        run_xfer("rd_edge", 1'b1, 24'h000014, 32'h0, 32'hCAFE_F00D, TO, 0, 1'b0);
        run_xfer("wr1", 1'b0, 24'h0ABCDE, 32'h8765_4321, 32'h0, 2, 0, 1'b0);

        // Reset while the high read phase is on the pads.
        drive_phase(1'b1, 1'b1, 16'h0000);
        drive_phase(1'b0, 1'b1, 16'h0018);
        bus.i_mib_ad = '0;
        tick();
        bus.i_cmd_ack   = 1'b1;
        bus.i_cmd_rdata = 32'h1111_2222;
        tick();
        bus.i_cmd_ack   = 1'b0;
        bus.i_cmd_rdata = '0;
        chk("mr_oe_before", 32'(bus.o_mib_ad_oe), 32'd1);
        chk("mr_ad_before", 32'(bus.o_mib_ad), 32'h1111);
        rst_n = 1'b0;
        #1;
        chk("mr_oe", 32'(bus.o_mib_ad_oe), 32'd0);
        chk("mr_ack", 32'(bus.o_mib_slave_ack), 32'd0);
        chk("mr_state", 32'(dbg_state), 32'(S_IDLE));
        chk("mr_addr", 32'(bus.o_cmd_byte_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_after_state", 32'(dbg_state), 32'(S_IDLE));
        chk("mr_after_oe", 32'(bus.o_mib_ad_oe), 32'd0);

        // Counter workload after reset: 2 writes, 1 read, 1 timeout.
        run_xfer("st_wr0", 1'b0, 24'h000020, 32'h0BAD_F00D, 32'h0, 2, 0, 1'b0);
        run_xfer("st_wr1", 1'b0, 24'h000024, 32'h7654_3210, 32'h0, 5, 0, 1'b0);
        run_xfer("st_rd0", 1'b1, 24'h000028, 32'h0, 32'h0F0F_0F0F, 1, 0, 1'b0);
        run_xfer("st_to0", 1'b1, 24'h00002C, 32'h0, 32'h0, 0, 0, 1'b0);
`ifdef MIB_SLAVE_STATS_EN
        chk("stat_wr", 32'(stat_wr), 32'd2);
        chk("stat_rd", 32'(stat_rd), 32'd1);
        chk("stat_to", 32'(stat_to), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
